inverter_test_sequencer: RTL and testbench

- Self-test controller for the inverter datapath inside the tt_um top.
- Steps a vector sequence onto the datapath input and waits a programmable settle time.
- Checks each returned word against the bitwise inverse of the driven word and reports pass/fail, a saturating error count and the first failing vector index.
- Owns the datapath input while busy. The top muxes between it and ui_in.

---
 rtl/inverter_test_sequencer.sv | 163 ++++++++++++++++
 tb/tb_inverter_test_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inverter_test_sequencer.sv
// rtl/inverter_test_sequencer.sv - self-test sequencer for the tt_um inverter datapath
//
// Drives a vector sequence into the inverter datapath, waits SETTLE cycles,
// checks each returned word against the bitwise inverse of the driven word
// and reports pass/fail, a saturating error count and the first failing index.
//
// Ports:
//   clk            in   clock
//   rst_n          in   synchronous active-low reset
//   ena            in   enable; when low every register holds
//   start          in   run request, only looked at in IDLE
//   dut_in         out  WIDTH  word driven into the datapath (holds last vector)
//   dut_out        in   WIDTH  word returned by the datapath
//   busy           out  high from DRIVE through DONE
//   done           out  one-cycle pulse at the end of a run
//   pass           out  result of the last run, held until the next start
//   err_count      out  ERR_W  mismatches in the last run, saturating
//   first_fail_idx out  8      first mismatching vector index, 8'hFF = none
//
// Build option: define INV_SEQ_LFSR_EN to take vectors from an 8-bit
// Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01) instead of the walking
// one/zero pattern. That build needs WIDTH == 8.

module inverter_test_sequencer #(
  parameter int WIDTH       = 8,
  parameter int SETTLE      = 2,
  parameter int NUM_VECTORS = 16,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       first_fail_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int              CNT_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);
  localparam logic [7:0]       LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  logic [2:0]       state;
  logic [7:0]       idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [WIDTH-1:0] pattern;
  logic             mismatch;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign mismatch = (dut_out != ~dut_in);

`ifdef INV_SEQ_LFSR_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;

  generate
    if (WIDTH != 8) begin : g_width_check
      $error("inverter_test_sequencer: INV_SEQ_LFSR_EN requires WIDTH == 8");
    end
  endgenerate

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign pattern   = WIDTH'(lfsr);

  // Reseeded on every accepted start so each run repeats the same sequence;
  // stepped in SAMPLE so the next DRIVE picks up the following value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 8'h01;
    end else if (ena) begin
      if (state == S_IDLE && start) begin
        lfsr <= 8'h01;
      end else if (state == S_SAMPLE) begin
        lfsr <= lfsr_next;
      end
    end
  end
`else
  // Walking one across the word, then walking zero, repeating every 2*WIDTH.
  always_comb begin
    logic [31:0] k;
    k = 32'(idx) % 32'(2 * WIDTH);
    if (k < 32'(WIDTH)) begin
      pattern = WIDTH'(1) << k;
    end else begin
      pattern = ~(WIDTH'(1) << (k - 32'(WIDTH)));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      dut_in         <= '0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= 8'hFF;
      idx            <= 8'd0;
      settle_cnt     <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_DRIVE;
            err_count      <= '0;
            first_fail_idx <= 8'hFF;
            pass           <= 1'b0;
            idx            <= 8'd0;
          end
        end
        S_DRIVE: begin
          dut_in     <= pattern;
          settle_cnt <= SETTLE_V;
          state      <= (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          // Counter holds the number of settle cycles still to spend here,
          // including the current one.
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt <= CNT_W'(1)) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + 1'b1;
            end
            // A saturating counter never returns to zero, so zero still
            // means no mismatch has been seen this run.
            if (err_count == '0) begin
              first_fail_idx <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 8'd1;
            state <= S_DRIVE;
          end
        end
        S_DONE: begin
          pass  <= (err_count == '0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverter_test_sequencer.sv
// tb/tb_inverter_test_sequencer.sv - self-checking bench for inverter_test_sequencer

module tb_inverter_test_sequencer;

  localparam int NV      = 16;
  localparam int RUN_LEN = NV * (2 + 2) + 1;

  typedef struct {
    int mode;       // 0 ideal, 1 stuck bit, 2 no inversion
    int fbit;
    bit fval;
    int gap_start;
    int gap_len;
    bit noise;      // extra start pulses during/at end of run
    int exp_done;
    int exp_err8;
    int exp_err3;
    int exp_first;
    bit exp_pass;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in, a_out, b_in, b_out;
  logic       a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [7:0] a_err, a_ff, b_ff;
  logic [2:0] b_err;

  int mode = 0;
  int fbit = 0;
  bit fval = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pat [NV];
  rec_t tbl [4];

  always #5 clk = ~clk;

  inverter_test_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_in(a_in), .dut_out(a_out), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_fail_idx(a_ff)
  );

  inverter_test_sequencer #(.ERR_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_in(b_in), .dut_out(b_out), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .first_fail_idx(b_ff)
  );

  function automatic logic [7:0] corrupt(input logic [7:0] good, input int m,
                                         input int fb, input bit fv);
    logic [7:0] r;
    r = good;
    if (m == 1) r[fb] = fv;
    else if (m == 2) r = ~good;
    return r;
  endfunction

  // Inverter datapath with one register stage, optionally faulty.
  always @(posedge clk) begin
    a_out <= corrupt(~a_in, mode, fbit, fval);
    b_out <= corrupt(~b_in, mode, fbit, fval);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input int m, input int fb, input bit fv,
                                output int e8, output int e3, output int first,
                                output bit ok);
    int cnt;
    cnt = 0;
    first = 8'hFF;
    for (int i = 0; i < NV; i++) begin
      if (corrupt(~pat[i], m, fb, fv) != ~pat[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    e8 = (cnt > 255) ? 255 : cnt;
    e3 = (cnt > 7) ? 7 : cnt;
    ok = (cnt == 0);
  endfunction

  task automatic run_seq(input rec_t r, input string tag);
    int lc;
    int a_first, b_first, done_hi, busy_bad, in_bad;
    mode = r.mode; fbit = r.fbit; fval = r.fval;
    @(negedge clk);
    start = 1'b1; ena = 1'b1;
    @(posedge clk);
    lc = 1; a_first = 0; b_first = 0; done_hi = 0; busy_bad = 0; in_bad = 0;
    for (int c = 1; c <= r.exp_done + 3; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, " pass_cleared"}, a_pass, 0);
      if (a_busy !== (lc <= RUN_LEN) || b_busy !== (lc <= RUN_LEN)) busy_bad++;
      if (a_done && a_first == 0) a_first = c;
      if (b_done && b_first == 0) b_first = c;
      if (a_done) done_hi++;
      if (lc % 4 == 0 && lc <= 4 * NV) begin
        if (a_in !== pat[lc / 4 - 1] || b_in !== pat[lc / 4 - 1]) in_bad++;
      end
      ena = !(c >= r.gap_start && c < r.gap_start + r.gap_len);
      start = r.noise && (c == 10 || c == 40 || c == r.exp_done);
      if (ena) lc++;
    end
    start = 1'b0; ena = 1'b1;
    chk({tag, " done_cycle"}, a_first, r.exp_done);
    chk({tag, " done_cycle3"}, b_first, r.exp_done);
    chk({tag, " done_width"}, done_hi, 1);
    chk({tag, " busy_window"}, busy_bad, 0);
    chk({tag, " dut_in_seq"}, in_bad, 0);
    chk({tag, " dut_in_hold"}, a_in, pat[NV-1]);
    chk({tag, " err_count"}, a_err, r.exp_err8);
    chk({tag, " err_count3"}, b_err, r.exp_err3);
    chk({tag, " first_fail"}, a_ff, r.exp_first);
    chk({tag, " first_fail3"}, b_ff, r.exp_first);
    chk({tag, " pass"}, a_pass, r.exp_pass);
    chk({tag, " pass3"}, b_pass, r.exp_pass);
  endtask

  initial begin
    rec_t rr;
    logic [7:0] l;
`ifdef INV_SEQ_LFSR_EN
    l = 8'h01;
    for (int i = 0; i < NV; i++) begin
      pat[i] = l;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
`else
    l = 8'h00;
    for (int i = 0; i < NV; i++) begin
      int k;
      k = i % 16;
      pat[i] = (k < 8) ? 8'(1 << k) : ~8'(1 << (k - 8));
    end
`endif
    tbl[0] = '{0, 0, 1'b0, 0,  0,  1'b0, 65, 0,  0, 8'hFF, 1'b1};
`ifdef INV_SEQ_LFSR_EN
    tbl[1] = '{1, 3, 1'b0, 0,  0,  1'b0, 65, 11, 7, 0,     1'b0};
`else
    tbl[1] = '{1, 3, 1'b0, 0,  0,  1'b0, 65, 8,  7, 0,     1'b0};
`endif
    tbl[2] = '{2, 0, 1'b0, 0,  0,  1'b0, 65, 16, 7, 0,     1'b0};
    tbl[3] = '{0, 0, 1'b0, 20, 10, 1'b1, 75, 0,  0, 8'hFF, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", a_busy, 0);
    chk("rst done", a_done, 0);
    chk("rst pass", a_pass, 0);
    chk("rst err", a_err, 0);
    chk("rst first_fail", a_ff, 8'hFF);
    chk("rst dut_in", a_in, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 4; t++) run_seq(tbl[t], $sformatf("tbl%0d", t));

    // Reset in the middle of a failing run.
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("pre_rst err_nonzero", (a_err != 0), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy", a_busy, 0);
    chk("midrst dut_in", a_in, 0);
    chk("midrst err", a_err, 0);
    chk("midrst err3", b_err, 0);
    chk("midrst first_fail", a_ff, 8'hFF);
    chk("midrst done", a_done, 0);
    rst_n = 1'b1;
    run_seq(tbl[0], "post_rst");

    for (int t = 0; t < 6; t++) begin
      rr.mode = $urandom_range(0, 2);
      rr.fbit = $urandom_range(0, 7);
      rr.fval = 1'($urandom_range(0, 1));
      rr.gap_start = $urandom_range(2, 40);
      rr.gap_len = $urandom_range(0, 15);
      rr.noise = 1'($urandom_range(0, 1));
      rr.exp_done = RUN_LEN + rr.gap_len;
      model(rr.mode, rr.fbit, rr.fval, rr.exp_err8, rr.exp_err3, rr.exp_first, rr.exp_pass);
      run_seq(rr, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
